// File: rtl/risc16_pkg.sv
// Shared register-file definitions for the 16-bit core: widths, register count
// and the writeback request record.
package risc16_pkg;
    localparam int REG_W      = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_W-1:0]      data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Load-writeback FIFO: a ring of DEPTH slots with a per-slot valid bit so the
// parent can see every buffered destination at once.
module wb_fifo
    import risc16_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [ADDR_W-1:0]             push_dest_i,
    input  logic [DATA_W-1:0]             push_data_i,
    input  logic                          pop_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [ADDR_W-1:0]             head_dest_o,
    output logic [DATA_W-1:0]             head_data_o,
    output logic [DEPTH-1:0]              ent_vld_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_dest_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0][ADDR_W-1:0] dest_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [PW-1:0]                wr_q, rd_q;
    logic                         push_ok, pop_ok;

    // Full when the write slot is still occupied, empty when the read slot is free.
    assign full_o      = vld_q[wr_q];
    assign empty_o     = !vld_q[rd_q];
    assign push_ok     = push_i && !full_o;
    assign pop_ok      = pop_i && !empty_o;
    assign head_dest_o = dest_q[rd_q];
    assign head_data_o = data_q[rd_q];
    assign ent_vld_o   = vld_q;
    assign ent_dest_o  = dest_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            if (push_ok) begin
                vld_q[wr_q] <= 1'b1;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                vld_q[rd_q] <= 1'b0;
                rd_q        <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            dest_q[wr_q] <= push_dest_i;
            data_q[wr_q] <= push_data_i;
        end
    end
endmodule

// File: rtl/gpr_writeback.sv
// Register-file write-port sequencer: merges ALU and buffered load results into
// one registered write per cycle. GPR_WB_FWD_EN adds a same-cycle bypass port.
module gpr_writeback
    import risc16_pkg::*;
#(
    parameter int DATA_W     = REG_W,
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [ADDR_W-1:0]       alu_dest,
    input  logic [DATA_W-1:0]       alu_data,
    output logic                    alu_ready,
    input  logic                    ld_valid,
    input  logic [ADDR_W-1:0]       ld_dest,
    input  logic [DATA_W-1:0]       ld_data,
    output logic                    ld_ready,
    output logic [(1<<ADDR_W)-1:0]  pend_mask,
`ifdef GPR_WB_FWD_EN
    input  logic [ADDR_W-1:0]       fwd_addr_1,
    input  logic [ADDR_W-1:0]       fwd_addr_2,
    output logic                    fwd_hit_1,
    output logic                    fwd_hit_2,
    output logic [DATA_W-1:0]       fwd_data_1,
    output logic [DATA_W-1:0]       fwd_data_2,
`endif
    output logic                    write_en,
    output logic [ADDR_W-1:0]       write_dest,
    output logic [DATA_W-1:0]       write_data
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic                         full, empty, pop, push;
    logic                         force_drain, alu_xfer, alu_win;
    logic [ADDR_W-1:0]            head_dest;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0]             ent_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_dest;
    logic [SW-1:0]                starve_q, starve_d;
    logic                         wen_q;
    logic [ADDR_W-1:0]            wdest_q;
    logic [DATA_W-1:0]            wdata_q;

    wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dest_i(ld_dest),
        .push_data_i(ld_data),
        .pop_i      (pop),
        .full_o     (full),
        .empty_o    (empty),
        .head_dest_o(head_dest),
        .head_data_o(head_data),
        .ent_vld_o  (ent_vld),
        .ent_dest_o (ent_dest)
    );

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_vld[i]) pend_mask[ent_dest[i]] = 1'b1;
    end

    assign force_drain = (starve_q == SW'(STARVE_MAX)) && !empty;
    assign alu_ready   = !rst && !pend_mask[alu_dest] && !force_drain;
    assign ld_ready    = !rst && !full;
    assign alu_xfer    = alu_valid && alu_ready;
    // Writes to r0 are swallowed here so they never occupy the port or the FIFO.
    assign alu_win     = alu_xfer && (alu_dest != '0);
    assign push        = ld_valid && ld_ready && (ld_dest != '0);
    assign pop         = !alu_win && !empty;

    always_comb begin
        starve_d = starve_q;
        if (empty || pop)
            starve_d = '0;
        else if (alu_win && starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            wen_q    <= 1'b0;
            wdest_q  <= '0;
            wdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            if (alu_win) begin
                wen_q   <= 1'b1;
                wdest_q <= alu_dest;
                wdata_q <= alu_data;
            end else if (!empty) begin
                wen_q   <= 1'b1;
                wdest_q <= head_dest;
                wdata_q <= head_data;
            end else begin
                wen_q   <= 1'b0;
            end
        end
    end

    assign write_en   = wen_q;
    assign write_dest = wdest_q;
    assign write_data = wdata_q;

`ifdef GPR_WB_FWD_EN
    assign fwd_hit_1  = wen_q && (wdest_q == fwd_addr_1) && (fwd_addr_1 != '0);
    assign fwd_hit_2  = wen_q && (wdest_q == fwd_addr_2) && (fwd_addr_2 != '0);
    assign fwd_data_1 = wdata_q;
    assign fwd_data_2 = wdata_q;
`endif
endmodule

// File: tb/tb_gpr_writeback.sv
// Directed bench for gpr_writeback: handshakes, load latency, hazards,
// starvation bound, FIFO back-pressure, r0 discard and mid-run reset.
module tb_gpr_writeback;
    import risc16_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, ld_valid, ld_ready;
    logic [2:0]  alu_dest, ld_dest, write_dest;
    logic [15:0] alu_data, ld_data, write_data;
    logic [7:0]  pend_mask;
    logic        write_en;

    int n_chk  = 0;
    int n_fail = 0;
    wb_req_t log_q[$];

    gpr_writeback #(.DATA_W(16), .ADDR_W(3), .DEPTH(4), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_dest  (alu_dest),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .ld_valid  (ld_valid),
        .ld_dest   (ld_dest),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .pend_mask (pend_mask),
        .write_en  (write_en),
        .write_dest(write_dest),
        .write_data(write_data)
    );

    always #5 clk = ~clk;

    // Record what the register file commits each cycle.
    always @(negedge clk) begin
        if (write_en) begin
            wb_req_t r;
            r.dest = write_dest;
            r.data = write_data;
            log_q.push_back(r);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'h1111;
        ld_valid = 1'b1; ld_dest = 3'd2; ld_data = 16'h2222;
        tick; tick;
        n_chk++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ready got %b exp 0", alu_ready); end
        n_chk++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready got %b exp 0", ld_ready); end
        n_chk++; if ({write_en, write_dest, write_data} !== 20'h0) begin n_fail++;
            $display("FAIL reset_write got en=%b d=%0d v=%h exp 0/0/0000", write_en, write_dest, write_data); end
        n_chk++; if (pend_mask !== 8'h00) begin n_fail++; $display("FAIL reset_pend got %h exp 00", pend_mask); end
        alu_valid = 1'b0; ld_valid = 1'b0; rst = 1'b0;
        tick;
    endtask

    task automatic test_alu;
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'h1234;
        #1;
        n_chk++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready got %b exp 1", alu_ready); end
        tick;
        alu_valid = 1'b0;
        n_chk++; if ({write_en, write_dest, write_data} !== {1'b1, 3'd3, 16'h1234}) begin n_fail++;
            $display("FAIL alu_write got en=%b d=%0d v=%h exp 1/3/1234", write_en, write_dest, write_data); end
        tick;
        n_chk++; if ({write_en, write_dest, write_data} !== {1'b0, 3'd3, 16'h1234}) begin n_fail++;
            $display("FAIL alu_idle_hold got en=%b d=%0d v=%h exp 0/3/1234", write_en, write_dest, write_data); end
    endtask

    task automatic test_load;
        ld_valid = 1'b1; ld_dest = 3'd5; ld_data = 16'hBEEF;
        #1;
        n_chk++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL ld_ready got %b exp 1", ld_ready); end
        tick;
        ld_valid = 1'b0;
        n_chk++; if (pend_mask !== 8'h20) begin n_fail++; $display("FAIL ld_pend got %h exp 20", pend_mask); end
        n_chk++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL ld_no_bypass got en=%b exp 0", write_en); end
        tick;
        n_chk++; if ({write_en, write_dest, write_data} !== {1'b1, 3'd5, 16'hBEEF}) begin n_fail++;
            $display("FAIL ld_write got en=%b d=%0d v=%h exp 1/5/beef", write_en, write_dest, write_data); end
        n_chk++; if (pend_mask !== 8'h00) begin n_fail++; $display("FAIL ld_pend_clear got %h exp 00", pend_mask); end
        tick;
    endtask

    task automatic test_hazard;
        ld_valid = 1'b1; ld_dest = 3'd2; ld_data = 16'h2222;
        tick;
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'hA0A0;
        #1;
        n_chk++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_block got %b exp 0", alu_ready); end
        tick;
        n_chk++; if ({write_en, write_dest, write_data} !== {1'b1, 3'd2, 16'h2222}) begin n_fail++;
            $display("FAIL hazard_load_first got en=%b d=%0d v=%h exp 1/2/2222", write_en, write_dest, write_data); end
        n_chk++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL hazard_release got %b exp 1", alu_ready); end
        tick;
        alu_valid = 1'b0;
        n_chk++; if ({write_en, write_dest, write_data} !== {1'b1, 3'd2, 16'hA0A0}) begin n_fail++;
            $display("FAIL hazard_alu_second got en=%b d=%0d v=%h exp 1/2/a0a0", write_en, write_dest, write_data); end
        tick;
    endtask

    task automatic test_starve;
        ld_valid = 1'b1; ld_dest = 3'd4; ld_data = 16'h4444;
        tick;
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_dest = 3'd1;
        for (int k = 0; k < 4; k++) begin
            alu_data = 16'(k + 1);
            #1;
            n_chk++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL starve_alu_win%0d got %b exp 1", k, alu_ready); end
            tick;
            n_chk++; if ({write_en, write_dest, write_data} !== {1'b1, 3'd1, 16'(k + 1)}) begin n_fail++;
                $display("FAIL starve_alu_write%0d got en=%b d=%0d v=%h exp 1/1/%h", k, write_en, write_dest, write_data, 16'(k + 1)); end
        end
        alu_data = 16'h0005;
        #1;
        n_chk++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL starve_drain_ready got %b exp 0", alu_ready); end
        tick;
        n_chk++; if ({write_en, write_dest, write_data} !== {1'b1, 3'd4, 16'h4444}) begin n_fail++;
            $display("FAIL starve_load got en=%b d=%0d v=%h exp 1/4/4444", write_en, write_dest, write_data); end
        tick;
        alu_valid = 1'b0;
        n_chk++; if ({write_en, write_dest, write_data} !== {1'b1, 3'd1, 16'h0005}) begin n_fail++;
            $display("FAIL starve_alu_resume got en=%b d=%0d v=%h exp 1/1/0005", write_en, write_dest, write_data); end
        tick;
    endtask

    task automatic test_fifo_full;
        logic [2:0]  dests [5];
        wb_req_t     got [$];
        dests = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        log_q.delete();
        alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'h0111;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_dest = dests[i]; ld_data = 16'(16'hD0 + i);
            #1;
            if (i == 4) begin
                n_chk++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL full_ld_ready got %b exp 0", ld_ready); end
            end
            for (int c = 0; c < 20 && !ld_ready; c++) tick;
            n_chk++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL full_timeout load %0d got ready=%b exp 1", i, ld_ready); end
            tick;
        end
        ld_valid = 1'b0; alu_valid = 1'b0;
        repeat (10) tick;
        foreach (log_q[j]) if (log_q[j].dest != 3'd1) got.push_back(log_q[j]);
        n_chk++; if (got.size() !== 5) begin n_fail++; $display("FAIL full_count got %0d exp 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_chk++; if (got[i].dest !== dests[i] || got[i].data !== 16'(16'hD0 + i)) begin n_fail++;
                $display("FAIL full_order%0d got %0d/%h exp %0d/%h", i, got[i].dest, got[i].data, dests[i], 16'(16'hD0 + i)); end
        end
    endtask

    task automatic test_zero;
        ld_valid = 1'b1; ld_dest = 3'd6; ld_data = 16'h6666;
        tick;
        alu_valid = 1'b1; alu_dest = 3'd0; alu_data = 16'hFFFF;
        ld_dest = 3'd0; ld_data = 16'hEEEE;
        #1;
        n_chk++; if ({alu_ready, ld_ready} !== 2'b11) begin n_fail++; $display("FAIL zero_ready got %b exp 11", {alu_ready, ld_ready}); end
        tick;
        alu_valid = 1'b0; ld_valid = 1'b0;
        n_chk++; if ({write_en, write_dest, write_data} !== {1'b1, 3'd6, 16'h6666}) begin n_fail++;
            $display("FAIL zero_drain got en=%b d=%0d v=%h exp 1/6/6666", write_en, write_dest, write_data); end
        n_chk++; if (pend_mask !== 8'h00) begin n_fail++; $display("FAIL zero_pend got %h exp 00", pend_mask); end
        tick;
        n_chk++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL zero_no_write got %b exp 0", write_en); end
    endtask

    task automatic test_reset_mid;
        logic [2:0] dests [3];
        dests = '{3'd3, 3'd4, 3'd5};
        alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'h0777;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_dest = dests[i]; ld_data = 16'(16'hC0 + i);
            tick;
        end
        ld_valid = 1'b0; alu_valid = 1'b0;
        n_chk++; if (pend_mask !== 8'h38) begin n_fail++; $display("FAIL mid_pend got %h exp 38", pend_mask); end
        rst = 1'b1;
        #1;
        n_chk++; if ({alu_ready, ld_ready} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_ready got %b exp 00", {alu_ready, ld_ready}); end
        tick;
        rst = 1'b0;
        n_chk++; if (pend_mask !== 8'h00 || write_en !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst_state got pend=%h en=%b exp 00/0", pend_mask, write_en); end
        log_q.delete();
        repeat (6) tick;
        n_chk++; if (log_q.size() !== 0) begin n_fail++; $display("FAIL mid_no_writes got %0d writes exp 0", log_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_alu;
        test_load;
        test_hazard;
        test_starve;
        test_fifo_full;
        test_zero;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gpr_writeback.md
# gpr_writeback

Write-port sequencer for the 8x16 general-purpose register file: the only driver of the register file's `write_en` / `write_dest` / `write_data` inputs. It merges two writeback sources, the single-cycle ALU result and the variable-latency load result, into one registered write per cycle. Loads are buffered in a small FIFO, and per-register pending bits stop an ALU write from overtaking an older load to the same register. It sits between execute/memory and the register file.

## Interface
Parameters:
- `DATA_W`, 16, register width
- `ADDR_W`, 3, register index width (8 registers)
- `DEPTH`, 4, load FIFO entries (power of two, ≥2)
- `STARVE_MAX`, 4, consecutive ALU wins allowed while a load waits

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: synchronous active-high reset
- `alu_valid` in 1: ALU result offered
- `alu_dest` in ADDR_W: ALU destination
- `alu_data` in DATA_W: ALU result
- `alu_ready` out 1: ALU result accepted this edge (comb.)
- `ld_valid` in 1: load result offered
- `ld_dest` in ADDR_W: load destination
- `ld_data` in DATA_W: load data
- `ld_ready` out 1: load accepted this edge (comb.)
- `pend_mask` out 8: bit i set while any FIFO entry targets register i (comb.)
- `write_en` out 1: to register-file write enable (registered)
- `write_dest` out ADDR_W: to register-file write index (registered)
- `write_data` out DATA_W: to register-file write data (registered)

## Operation
- Handshake: a transfer happens on an edge where valid && ready. Producers hold valid, dest and data stable until the transfer.
- `ld_ready` = !rst && !full. It does not look at a same-cycle dequeue, so a full FIFO never accepts.
- `alu_ready` = !rst && !pend_mask[alu_dest] && !force_drain.
- force_drain = (starve_cnt == STARVE_MAX) && FIFO non-empty.
- Output register selection each edge, in priority order:
  1. ALU transfer with `alu_dest` != 0 → load `write_*` with the ALU result, `write_en`=1.
  2. Else if the FIFO is non-empty → dequeue the head into `write_*`, `write_en`=1.
  3. Else → `write_en`=0; `write_dest` and `write_data` hold their values.
- Register 0 is hardwired zero:
  - An ALU transfer to register 0 is accepted and discarded; the FIFO may drain in that same cycle.
  - A load transfer to register 0 is accepted and not enqueued.
- starve_cnt (0..STARVE_MAX):
  - Increments on an ALU-won edge while the FIFO is non-empty.
  - Clears on any dequeue, or while the FIFO is empty.
- Simultaneous enqueue and dequeue on a non-full FIFO: both take effect and occupancy is unchanged.
- `pend_mask` is the OR of one-hot(dest) over valid FIFO entries. The entry currently in `write_*` is not pending, because later writes commit after it.

## Timing
- Reset values: `write_en`=0, `write_dest`=0, `write_data`=0, FIFO empty, starve_cnt=0, `pend_mask`=0. `alu_ready` and `ld_ready` are 0 while `rst` is high.
- Reset mid-operation discards every buffered load and any registered write on that edge.
- ALU latency: accepted at edge N → `write_*` valid during cycle N+1 → register file commits at edge N+1.
- Load latency: enqueued at edge N → dequeued at edge N+1 at the earliest → commits at edge N+2. There is no empty-FIFO bypass.
- Throughput: one register write per cycle.
- Worst-case load wait behind continuous ALU traffic: STARVE_MAX+1 edges.

## Configuration
- `GPR_WB_FWD_EN` defined:
  - Adds inputs `fwd_addr_1` and `fwd_addr_2` (ADDR_W each).
  - Adds outputs `fwd_hit_1`, `fwd_hit_2` (1 bit) and `fwd_data_1`, `fwd_data_2` (DATA_W).
  - fwd_hit_k = `write_en` && `write_dest` == fwd_addr_k && fwd_addr_k != 0. fwd_data_k = `write_data`. All combinational.
  - Gives same-cycle bypass of the write that commits at the next edge.
- `GPR_WB_FWD_EN` undefined: these ports and this logic are absent.

## Structure
- Shared package `risc16_pkg`: `REG_W`=16, `REG_ADDR_W`=3, `NUM_REGS`=8, and a `wb_req_t` struct {dest, data}.
- One sub-module, `wb_fifo`: a synchronous FIFO with DEPTH entries, push/pop, full/empty flags, and parallel entry-valid/dest outputs used to build `pend_mask`.

## Test plan
- Reset, then ALU valid with dest 3, data 0x1234 → `alu_ready`=1; next cycle `write_en`=1, `write_dest`=3, `write_data`=0x1234.
- Load dest 5, data 0xBEEF with no ALU traffic → `pend_mask`=0x20 for one cycle; write appears 2 cycles after the load handshake.
- Load dest 2 pending, then ALU dest 2 → `alu_ready`=0 until the load drains. The register file commits the load value, then the ALU value.
- Continuous ALU writes to dest 1 while one load to dest 4 waits, STARVE_MAX=4 → the load commits after exactly 4 ALU writes; `alu_ready`=0 on the drain edge.
- 5 back-to-back loads with DEPTH=4 and the ALU saturating the port → `ld_ready`=0 on the 5th; no data lost, and commits come out in FIFO order.
- ALU and load both to dest 0 → both accepted, `write_en` stays 0. Asserting `rst` with 3 loads queued → `pend_mask`=0 and no writes afterwards.
